// File: rtl/elevator_scan_ctrl.sv
// SCAN-style single-car elevator controller: latches car/hall calls, keeps
// travelling in one direction while calls remain ahead, then reverses.
module elevator_scan_ctrl #(
   parameter  int NUM_FLOORS = 8,
   parameter  int TRAVEL_CYC = 4,
   parameter  int DOOR_CYC   = 6,
   localparam int FW         = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] i_car_req,
   input  logic [NUM_FLOORS-1:0] i_hall_req,
   input  logic                  i_emergency,
   input  logic                  i_emer_resolve,
   input  logic                  i_door_obstruct,
   output logic [FW-1:0]         o_cur_floor,
   output logic [2:0]            o_state,
   output logic                  o_door_open,
   output logic [NUM_FLOORS-1:0] o_pending,
   output logic                  o_arrive
);

   localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
   localparam int DW = $clog2(DOOR_CYC + 1);
   localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_UP   = 3'd1,
      S_DOWN = 3'd2,
      S_DOOR = 3'd3,
      S_EMER = 3'd4
   } state_t;

   state_t                  state, state_n;
   logic [FW-1:0]           cur_floor, floor_n, nf;
   logic [NUM_FLOORS-1:0]   pending, pend_n, req_now, pend_eff;
   logic                    dir_up, dir_n;
   logic [TW-1:0]           travel_cnt, cnt_n;
   logic [DW-1:0]           door_tmr, tmr_n;
   logic                    arrive, open_entry;

   function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] f);
      any_above = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i > int'(f)) any_above = any_above | m[i];
   endfunction

   function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] f);
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i < int'(f)) any_below = any_below | m[i];
   endfunction

   // Decisions look at latched calls plus this cycle's buttons, so a press
   // arriving on the deciding cycle is honoured without an extra cycle of lag.
   always_comb begin
      req_now    = i_car_req | i_hall_req;
      pend_eff   = pending | req_now;
      state_n    = state;
      floor_n    = cur_floor;
      cnt_n      = travel_cnt;
      tmr_n      = door_tmr;
      dir_n      = dir_up;
      pend_n     = pend_eff;
      open_entry = 1'b0;
      nf         = cur_floor;

      case (state)
         S_IDLE: begin
            if (pend_eff[cur_floor]) begin
               state_n    = S_DOOR;
               open_entry = 1'b1;
            end else if (any_above(pend_eff, cur_floor) &&
                         (dir_up || !any_below(pend_eff, cur_floor))) begin
               state_n = S_UP;
               dir_n   = 1'b1;
               cnt_n   = '0;
            end else if (any_below(pend_eff, cur_floor)) begin
               state_n = S_DOWN;
               dir_n   = 1'b0;
               cnt_n   = '0;
            end
         end

         S_UP, S_DOWN: begin
            if (travel_cnt == TW'(TRAVEL_CYC - 1)) begin
               cnt_n = '0;
               if (state == S_UP)
                  nf = (cur_floor == TOP) ? cur_floor : cur_floor + 1'b1;
               else
                  nf = (cur_floor == '0) ? cur_floor : cur_floor - 1'b1;
               floor_n = nf;
               if (pend_eff[nf]) begin
                  state_n    = S_DOOR;
                  open_entry = 1'b1;
               end else if ((state == S_UP) ? any_above(pend_eff, nf)
                                            : any_below(pend_eff, nf)) begin
                  state_n = state;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = travel_cnt + 1'b1;
            end
         end

         S_DOOR: begin
            // A press for the open floor only extends the door; it is never queued.
            pend_n[cur_floor] = pending[cur_floor];
            if (i_door_obstruct || req_now[cur_floor]) begin
               tmr_n = DW'(DOOR_CYC);
            end else if (door_tmr <= DW'(1)) begin
               state_n = S_IDLE;
               tmr_n   = '0;
            end else begin
               tmr_n = door_tmr - 1'b1;
            end
         end

         S_EMER: begin
            pend_n = pending;
            if (i_emer_resolve && !i_emergency) state_n = S_IDLE;
         end

         default: state_n = S_IDLE;
      endcase

      if (open_entry) tmr_n = DW'(DOOR_CYC);

      // Emergency overrides every other transition and discards partial travel.
      if (state != S_EMER && i_emergency) begin
         state_n    = S_EMER;
         floor_n    = cur_floor;
         cnt_n      = '0;
         tmr_n      = '0;
         dir_n      = dir_up;
         open_entry = 1'b0;
      end

      if (open_entry) pend_n[floor_n] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cur_floor  <= '0;
         pending    <= '0;
         dir_up     <= 1'b1;
         travel_cnt <= '0;
         door_tmr   <= '0;
         arrive     <= 1'b0;
      end else begin
         state      <= state_n;
         cur_floor  <= floor_n;
         pending    <= pend_n;
         dir_up     <= dir_n;
         travel_cnt <= cnt_n;
         door_tmr   <= tmr_n;
         arrive     <= open_entry;
      end
   end

   assign o_cur_floor = cur_floor;
   assign o_state     = state;
   assign o_door_open = (state == S_DOOR);
   assign o_pending   = pending;
   assign o_arrive    = arrive;

   a_floor_range: assert property (@(posedge clk) disable iff (rst) cur_floor <= TOP);
   a_arrive_door: assert property (@(posedge clk) disable iff (rst) arrive |-> state == S_DOOR);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed vector table, a door-reload sequence,
// and random traffic compared against a floor/queue level reference model.
module tb_elevator_scan_ctrl;

   localparam int NF = 8;
   localparam int TC = 4;
   localparam int DC = 6;
   localparam int ST_IDLE = 0, ST_UP = 1, ST_DOWN = 2, ST_DOOR = 3, ST_EMER = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] car, hall;
   logic          emer, res, obs;
   logic [2:0]    cur_floor;
   logic [2:0]    state;
   logic          door;
   logic [NF-1:0] pend;
   logic          arrive;

   int checks = 0;
   int errors = 0;

   elevator_scan_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYC(TC), .DOOR_CYC(DC)) dut (
      .clk(clk), .rst(rst), .i_car_req(car), .i_hall_req(hall),
      .i_emergency(emer), .i_emer_resolve(res), .i_door_obstruct(obs),
      .o_cur_floor(cur_floor), .o_state(state), .o_door_open(door),
      .o_pending(pend), .o_arrive(arrive)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_mode, m_floor, m_prog, m_door;
   bit            m_up, m_arr;
   logic [NF-1:0] m_pend;

   function automatic bit has_req(input logic [NF-1:0] m, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         if (i >= 0 && i < NF && m[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic open_door();
      m_mode = ST_DOOR;
      m_door = DC;
      m_pend[m_floor] = 1'b0;
      m_arr = 1'b1;
   endtask

   task automatic m_step(input bit r, input logic [NF-1:0] c, input logic [NF-1:0] h,
                         input bit e, input bit rv, input bit ob);
      logic [NF-1:0] req, eff;
      bit going_up;
      req = c | h;
      eff = m_pend | req;
      m_arr = 1'b0;
      if (r) begin
         m_mode = ST_IDLE; m_floor = 0; m_pend = '0; m_up = 1'b1; m_prog = 0; m_door = 0;
         return;
      end
      if (m_mode != ST_EMER && e) begin
         if (m_mode == ST_DOOR) req[m_floor] = 1'b0;
         m_pend |= req;
         m_mode = ST_EMER; m_prog = 0; m_door = 0;
         return;
      end
      case (m_mode)
         ST_EMER: if (rv && !e) m_mode = ST_IDLE;
         ST_DOOR: begin
            if (ob || req[m_floor]) m_door = DC;
            else if (m_door == 1) begin m_mode = ST_IDLE; m_door = 0; end
            else m_door--;
            req[m_floor] = 1'b0;
            m_pend |= req;
         end
         ST_IDLE: begin
            m_pend |= req;
            if (eff[m_floor]) open_door();
            else if (has_req(eff, m_floor + 1, NF - 1) &&
                     (m_up || !has_req(eff, 0, m_floor - 1))) begin
               m_mode = ST_UP; m_up = 1'b1; m_prog = 0;
            end else if (has_req(eff, 0, m_floor - 1)) begin
               m_mode = ST_DOWN; m_up = 1'b0; m_prog = 0;
            end
         end
         default: begin
            m_pend |= req;
            m_prog++;
            if (m_prog == TC) begin
               m_prog = 0;
               going_up = (m_mode == ST_UP);
               if (going_up) m_floor = (m_floor + 1 > NF - 1) ? NF - 1 : m_floor + 1;
               else          m_floor = (m_floor - 1 < 0) ? 0 : m_floor - 1;
               if (eff[m_floor]) open_door();
               else if (going_up ? has_req(eff, m_floor + 1, NF - 1)
                                 : has_req(eff, 0, m_floor - 1)) ;
               else m_mode = ST_IDLE;
            end
         end
      endcase
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            r;
      logic [NF-1:0] c, h;
      bit            e, rv, ob;
      int            hold;
      int            st, fl;
      logic [NF-1:0] pd;
      bit            dr, ar;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input logic [NF-1:0] c, input logic [NF-1:0] h,
                      input bit e, input bit rv, input bit ob, input int hold,
                      input int st, input int fl, input logic [NF-1:0] pd,
                      input bit dr, input bit ar);
      vec_t v;
      v.r = r; v.c = c; v.h = h; v.e = e; v.rv = rv; v.ob = ob; v.hold = hold;
      v.st = st; v.fl = fl; v.pd = pd; v.dr = dr; v.ar = ar;
      tbl.push_back(v);
   endtask

   initial begin
      bit e_lvl;
      rst = 1'b0; car = '0; hall = '0; emer = 1'b0; res = 1'b0; obs = 1'b0;

      //  r  car    hall   e  rv ob hold  st       fl pend   dr ar
      add(1, 8'h00, 8'h00, 0, 0, 0, 2,  ST_IDLE, 0, 8'h00, 0, 0);
      add(0, 8'h08, 8'h00, 0, 0, 0, 1,  ST_UP,   0, 8'h08, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 11, ST_UP,   2, 8'h08, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_DOOR, 3, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 5,  ST_DOOR, 3, 8'h00, 1, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_IDLE, 3, 8'h00, 0, 0);
      add(0, 8'h08, 8'h00, 0, 0, 0, 1,  ST_DOOR, 3, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 1, 10, ST_DOOR, 3, 8'h00, 1, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 5,  ST_DOOR, 3, 8'h00, 1, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_IDLE, 3, 8'h00, 0, 0);
      add(0, 8'h02, 8'h00, 0, 0, 0, 1,  ST_DOWN, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 2,  ST_DOWN, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 1, 0, 0, 1,  ST_EMER, 3, 8'h02, 0, 0);
      add(0, 8'h80, 8'h01, 1, 0, 0, 3,  ST_EMER, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 1, 1, 0, 2,  ST_EMER, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 1, 0, 1,  ST_IDLE, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_DOWN, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 3,  ST_DOWN, 3, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_DOWN, 2, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 4,  ST_DOOR, 1, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 1, 8'h00, 0, 0);
      add(0, 8'h10, 8'h00, 0, 0, 0, 1,  ST_UP,   1, 8'h10, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 12, ST_DOOR, 4, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 4, 8'h00, 0, 0);
      add(0, 8'h40, 8'h02, 0, 0, 0, 1,  ST_UP,   4, 8'h42, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 8,  ST_DOOR, 6, 8'h02, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 6, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_DOWN, 6, 8'h02, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 20, ST_DOOR, 1, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 1, 8'h00, 0, 0);
      add(1, 8'hFF, 8'h00, 0, 0, 0, 2,  ST_IDLE, 0, 8'h00, 0, 0);
      add(0, 8'h20, 8'h00, 0, 0, 0, 1,  ST_UP,   0, 8'h20, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 4,  ST_UP,   1, 8'h20, 0, 0);
      add(0, 8'h00, 8'h04, 0, 0, 0, 1,  ST_UP,   1, 8'h24, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 3,  ST_DOOR, 2, 8'h20, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 2, 8'h20, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1,  ST_UP,   2, 8'h20, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 12, ST_DOOR, 5, 8'h00, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0, 0, 6,  ST_IDLE, 5, 8'h00, 0, 0);
      add(0, 8'h81, 8'h00, 0, 0, 0, 1,  ST_UP,   5, 8'h81, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 2,  ST_UP,   5, 8'h81, 0, 0);
      add(1, 8'h00, 8'h00, 0, 0, 0, 1,  ST_IDLE, 0, 8'h00, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0, 0, 10, ST_IDLE, 0, 8'h00, 0, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].r; car = tbl[i].c; hall = tbl[i].h;
         emer = tbl[i].e; res = tbl[i].rv; obs = tbl[i].ob;
         repeat (tbl[i].hold) @(posedge clk);
         #1;
         chk($sformatf("row%0d_state", i), state, tbl[i].st);
         chk($sformatf("row%0d_floor", i), cur_floor, tbl[i].fl);
         chk($sformatf("row%0d_pending", i), pend, tbl[i].pd);
         chk($sformatf("row%0d_door", i), door, tbl[i].dr);
         chk($sformatf("row%0d_arrive", i), arrive, tbl[i].ar);
      end
      rst = 1'b0; car = '0; hall = '0; emer = 1'b0; res = 1'b0; obs = 1'b0;

      // Door at floor 0: a hall press for the open floor reloads the timer and is not queued.
      car = 8'h01;
      @(posedge clk); #1; car = '0;
      chk("reload_entry_state", state, ST_DOOR);
      chk("reload_entry_arrive", arrive, 1);
      repeat (3) @(posedge clk);
      #1; hall = 8'h01;
      @(posedge clk); #1; hall = '0;
      chk("reload_not_latched", pend, 0);
      chk("reload_still_open", state, ST_DOOR);
      repeat (5) @(posedge clk);
      #1;
      chk("reload_extended", state, ST_DOOR);
      @(posedge clk); #1;
      chk("reload_close", state, ST_IDLE);
      chk("reload_pending", pend, 0);

      // Random traffic against the reference model.
      e_lvl = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         rst = (n < 2) || ($urandom_range(0, 299) == 0);
         car = '0; hall = '0;
         if ($urandom_range(0, 5) == 0) car[$urandom_range(0, NF - 1)] = 1'b1;
         if ($urandom_range(0, 7) == 0) hall[$urandom_range(0, NF - 1)] = 1'b1;
         if (!e_lvl) e_lvl = ($urandom_range(0, 99) == 0);
         else        e_lvl = ($urandom_range(0, 9) != 0);
         emer = e_lvl;
         res  = ($urandom_range(0, 3) == 0);
         obs  = ($urandom_range(0, 9) == 0);
         @(posedge clk);
         m_step(rst, car, hall, emer, res, obs);
         #1;
         chk("rnd_state", state, m_mode);
         chk("rnd_floor", cur_floor, m_floor);
         chk("rnd_pending", pend, m_pend);
         chk("rnd_door", door, (m_mode == ST_DOOR) ? 1 : 0);
         chk("rnd_arrive", arrive, m_arr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of floors (legal 2..16), floors numbered 0..NUM_FLOORS-1.
REQ-002 Parameter TRAVEL_CYC, default 4, clock cycles to move one floor (legal >=1).
REQ-003 Parameter DOOR_CYC, default 6, clock cycles door stays open (legal >=1).
REQ-004 Derived FW = $clog2(NUM_FLOORS), floor index width.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_car_req  input  NUM_FLOORS  bitmask of in-car floor selections, sampled every cycle.
REQ-008 i_hall_req  input  NUM_FLOORS  bitmask of landing call buttons, sampled every cycle.
REQ-009 i_emergency  input  1  emergency stop request, level.
REQ-010 i_emer_resolve  input  1  emergency clear, level.
REQ-011 i_door_obstruct  input  1  door sensor blocked, level.
REQ-012 o_cur_floor  output  FW  current floor.
REQ-013 o_state  output  3  IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3, EMERGENCY=4.
REQ-014 o_door_open  output  1  high only in DOOR_OPEN.
REQ-015 o_pending  output  NUM_FLOORS  registered pending-request mask.
REQ-016 o_arrive  output  1  one-cycle pulse on entry to DOOR_OPEN.

Function
REQ-017 pending <= pending | i_car_req | i_hall_req each cycle, except in EMERGENCY where new requests are dropped and pending is held.
REQ-018 pending[cur_floor] clears on DOOR_OPEN entry; requests for cur_floor while in DOOR_OPEN are not latched and reload the door timer.
REQ-019 Register dir_up (reset 1) records last travel direction; updated on every MOVE_UP/MOVE_DOWN entry.
REQ-020 IDLE: pending[cur] set -> DOOR_OPEN; else requests above and (dir_up or none below) -> MOVE_UP; else requests below -> MOVE_DOWN; else stay IDLE. Decision uses pending OR current-cycle requests; transition next edge.
REQ-021 MOVE_*: travel counter counts 0..TRAVEL_CYC-1; on terminal count o_cur_floor +/-1 and counter clears.
REQ-022 On that same edge: pending bit (incl. same-cycle request) at new floor -> DOOR_OPEN; else further requests in current direction -> stay moving; else -> IDLE.
REQ-023 o_cur_floor saturates at 0 and NUM_FLOORS-1; no wrap-around under any input.
REQ-024 DOOR_OPEN: door timer loads DOOR_CYC on entry, decrements each cycle; i_door_obstruct high or a cur-floor request reloads DOOR_CYC; at 1 with no reload -> IDLE.
REQ-025 Door opens only when stationary; never asserted in MOVE_*, IDLE or EMERGENCY.
REQ-026 i_emergency high in any non-EMERGENCY state -> EMERGENCY next edge, priority over all transitions; o_cur_floor held, travel counter and door timer cleared, door closed.
REQ-027 EMERGENCY -> IDLE when i_emer_resolve=1 and i_emergency=0; if both high, remain EMERGENCY.
REQ-028 Mid-floor emergency abandons partial travel; after resolve, the next move restarts a full TRAVEL_CYC count.

Reset
REQ-029 rst high: state IDLE, o_cur_floor 0, pending 0, dir_up 1, counters 0, o_door_open 0, o_arrive 0; applies mid-travel and mid-door, takes priority over emergency.
REQ-030 Requests present during rst are dropped.

Verification (defaults 8/4/6)
REQ-031 Reset, pulse i_car_req[3] -> MOVE_UP next cycle; o_cur_floor 3 after 12 MOVE cycles; o_arrive pulse; door 6 cycles; IDLE; o_pending 0.
REQ-032 Moving 0->5, i_hall_req[2] pulsed while at floor 1 -> stops at 2, door 6 cycles, resumes to 5.
REQ-033 Idle at 4, dir_up=1, i_car_req[6] and i_hall_req[1] same cycle -> serves 6 first, then MOVE_DOWN to 1.
REQ-034 i_emergency mid-floor between 2 and 3 -> EMERGENCY next cycle, floor 2 held, door 0, new requests ignored; resolve -> IDLE, full 4-cycle travel to 3.
REQ-035 Door open at 3, i_door_obstruct held 10 cycles -> door open 10+6 cycles total from obstruct start, then IDLE.
REQ-036 rst pulsed mid-travel at floor 5 with pending bits -> all outputs at REQ-029 values next cycle; no movement afterward.
